// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
// Round-robin arbiter in front of a shared 4:1 data mux with one registered
// output channel. Each cycle the arbiter picks one requester, steers its word
// through the select path and captures it in the output register using a
// valid/ready handshake. Up to one word per cycle passes through.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   request per requester; bit k means requester k has a word on din
//   din        packed requester data; din[k*DATA_W +: DATA_W] is requester k
//   gnt[3:0]   one-hot acceptance; requester k's word is captured at this edge
//   out_valid  out_data/out_sel hold a valid word
//   out_ready  downstream accepts the word when out_valid && out_ready
//   out_data   registered selected word
//   out_sel    registered index of the requester that sourced out_data

module rr_mux_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          req,
    input  logic [4*DATA_W-1:0] din,
    output logic [3:0]          gnt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_sel
);

    logic [1:0]        ptr;
    logic              load_ok;
    logic              has_winner;
    logic [1:0]        winner;
    logic [1:0]        idx;
    logic [DATA_W-1:0] din_arr [4];

    // Split the packed data bus into one word per requester so the selected
    // word can be picked by index.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            din_arr[k] = din[k*DATA_W +: DATA_W];
        end
    end

    // The output register may take a new word when it is empty or when its
    // current word is being consumed this cycle.
    assign load_ok = !out_valid || out_ready;

    // Round-robin search starting at ptr. Scanning offsets from 3 down to 0
    // lets the smallest offset with a request overwrite the others, so no
    // early exit from the loop is needed; the 2-bit index wraps naturally.
    always_comb begin
        has_winner = 1'b0;
        winner     = ptr;
        idx        = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                has_winner = 1'b1;
                winner     = idx;
            end
        end
    end

    // The grant is combinational so a requester learns in the same cycle that
    // its word is captured at the coming edge. It is held at zero during reset.
    always_comb begin
        gnt = 4'b0000;
        if (rst_n && load_ok && has_winner) begin
            gnt[winner] = 1'b1;
        end
    end

    // Output register and pointer. A load replaces the word even when the
    // previous one is being consumed on the same edge, which gives
    // back-to-back throughput. A drain only clears valid; data, select and
    // pointer are held. During a stall nothing changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'b00;
            ptr       <= 2'b00;
        end else if (load_ok) begin
            if (has_winner) begin
                out_valid <= 1'b1;
                out_data  <= din_arr[winner];
                out_sel   <= winner;
                ptr       <= winner + 2'd1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Testbench for rr_mux_arbiter: reset checks, a table of directed vectors,
// randomized traffic against a behavioural model, and an asynchronous reset
// in the middle of a contention run.

module tb_rr_mux_arbiter;

    localparam int DATA_W = 8;

    logic                clk;
    logic                rst_n;
    logic [3:0]          req;
    logic [4*DATA_W-1:0] din;
    logic [3:0]          gnt;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_sel;

    int vec_count;
    int err_count;

    // Behavioural model state
    int          m_ptr;
    bit          m_valid;
    logic [7:0]  m_data;
    int          m_sel;
    logic [3:0]  last_gnt;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] din;
        logic        rdy;
        logic [3:0]  exp_gnt;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [1:0]  exp_sel;
    } vec_t;

    vec_t vecs[$];

    rr_mux_arbiter #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // First requester found scanning upwards (mod 4) from pointer p, or -1.
    function automatic int pick(logic [3:0] r, int p);
        for (int off = 0; off < 4; off++) begin
            if (r[(p + off) % 4]) return (p + off) % 4;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_data  = 8'h00;
        m_sel   = 0;
    endtask

    // Drive one cycle of inputs after the falling edge, check the grant before
    // the rising edge, advance the model at the edge and check the registers.
    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input logic rdy);
        int          w;
        bit          ld;
        logic [3:0]  eg;
        @(negedge clk);
        req       = r;
        din       = d;
        out_ready = rdy;
        #1;
        w  = pick(r, m_ptr);
        ld = !m_valid || rdy;
        eg = 4'b0000;
        if (ld && w >= 0) eg[w] = 1'b1;
        last_gnt = gnt;
        checkOutput("gnt", 32'(gnt), 32'(eg));
        @(posedge clk);
        if (ld) begin
            if (w >= 0) begin
                m_valid = 1;
                m_data  = d[w*8 +: 8];
                m_sel   = w;
                m_ptr   = (w + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            checkOutput("out_data", 32'(out_data), 32'(m_data));
            checkOutput("out_sel", 32'(out_sel), 32'(m_sel));
        end
    endtask

    task automatic add_vec(input logic [3:0] r, input logic [31:0] d, input logic rdy,
                           input logic [3:0] g, input logic v, input logic [7:0] od,
                           input logic [1:0] os);
        vec_t t;
        t.req = r; t.din = d; t.rdy = rdy;
        t.exp_gnt = g; t.exp_valid = v; t.exp_data = od; t.exp_sel = os;
        vecs.push_back(t);
    endtask

    initial begin
        logic [31:0] dd;
        vec_count = 0;
        err_count = 0;
        model_reset();

        dd = 32'h44332211;
        // Release from reset with req=1111 -> first grant to requester 0
        add_vec(4'b1111, dd, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
        add_vec(4'b0000, dd, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0);
        // Single requester 2 with A5
        add_vec(4'b0100, 32'h44A52211, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
        add_vec(4'b0000, dd, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2);
        // Bring the pointer back to 0
        add_vec(4'b1000, dd, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
        add_vec(4'b0000, dd, 1'b1, 4'b0000, 1'b0, 8'h44, 2'd3);
        // Full contention for 8 cycles
        for (int c = 0; c < 8; c++) begin
            logic [3:0] g;
            logic [7:0] od;
            g  = 4'b0001 << (c % 4);
            od = dd[(c % 4)*8 +: 8];
            add_vec(4'b1111, dd, 1'b1, g, 1'b1, od, 2'(c % 4));
        end
        // Backpressure with out_sel=01 held for 3 cycles
        add_vec(4'b1111, dd, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
        add_vec(4'b1111, dd, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
        add_vec(4'b1111, dd, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1);
        add_vec(4'b1111, dd, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1);
        add_vec(4'b1111, dd, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1);
        add_vec(4'b1111, dd, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
        // Skip idle requesters: ptr=1, req=1001
        add_vec(4'b0001, dd, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
        add_vec(4'b1001, dd, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
        add_vec(4'b1001, dd, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
        add_vec(4'b0000, dd, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0);

        // Reset held with all requests present
        rst_n     = 1'b0;
        req       = 4'b1111;
        din       = dd;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", 32'(out_data), 32'd0);
        checkOutput("rst_sel", 32'(out_sel), 32'd0);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].din, vecs[i].rdy);
            checkOutput($sformatf("tbl%0d_gnt", i), 32'(last_gnt), 32'(vecs[i].exp_gnt));
            checkOutput($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("tbl%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
            checkOutput($sformatf("tbl%0d_sel", i), 32'(out_sel), 32'(vecs[i].exp_sel));
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            applyStimulus(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset between clock edges during contention
        for (int n = 0; n < 3; n++) applyStimulus(4'b1111, dd, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid", 32'(out_valid), 32'd0);
        checkOutput("async_gnt", 32'(gnt), 32'd0);
        checkOutput("async_data", 32'(out_data), 32'd0);
        checkOutput("async_sel", 32'(out_sel), 32'd0);
        model_reset();
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;
        applyStimulus(4'b1111, dd, 1'b1);
        checkOutput("post_rst_gnt", 32'(last_gnt), 32'h1);
        applyStimulus(4'b1111, dd, 1'b1);
        checkOutput("post_rst_gnt2", 32'(last_gnt), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Round-robin arbiter that shares a 4-to-1 data multiplexer between four requesters and drives one registered output channel. Each cycle it picks one requester, steers that requester's data through the 4:1 select path and captures it in an output register with a valid/ready handshake. It sits in front of the 4:1 mux datapath and generates the 2-bit select that the bare mux otherwise needs from outside.

Parameters:
DATA_W, 8, width of each requester data word and of out_data

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  4  request per requester; bit k = requester k has a word on din
din  input  4*DATA_W  packed requester data; din[k*DATA_W +: DATA_W] belongs to requester k
gnt  output  4  one-hot acceptance; gnt[k]=1 means requester k's word is captured at this clock edge
out_valid  output  1  out_data/out_sel hold a valid word
out_ready  input  1  downstream accepts the word when out_valid && out_ready
out_data  output  DATA_W  registered selected word
out_sel  output  2  registered index of the requester that sourced out_data

Behaviour:
- State: output register (out_valid, out_data, out_sel) and a 2-bit round-robin pointer ptr.
- Reset (rst_n low, asynchronous, immediate): out_valid=0, out_data=0, out_sel=2'b00, ptr=0. gnt is forced to 4'b0000 while rst_n is low.
- load_ok = !out_valid || out_ready. This is a combinational function of the current state and out_ready.
- Winner selection is combinational. Search req starting at index ptr, ascending mod 4. The first set bit wins. With no set bit there is no winner.
- Load (load_ok && |req), at the clock edge:
  - out_data <= din slice of the winner
  - out_sel <= winner
  - out_valid <= 1
  - ptr <= (winner+1) mod 4
  - In the same cycle gnt = one-hot(winner). gnt is combinational, asserts in the cycle before the edge, and never has more than one bit set.
- Drain (load_ok && !(|req)): out_valid <= 0. out_data, out_sel and ptr are held. gnt=0.
- Stall (out_valid && !out_ready): all registers are held and gnt=0. A requester keeps req and din stable until it sees gnt.
- Simultaneous transfer and load: when out_valid=1, out_ready=1 and a request is present, the old word is consumed and the new word is loaded on the same edge. out_valid stays 1 and there is no bubble. Sustained throughput is one word per cycle.
- Latency: a word granted in cycle n appears on out_data with out_valid=1 in cycle n+1.
- Fairness: a requester holding req continuously is granted within 4 load opportunities. ptr wraps from 3 to 0.
- req dropping without a grant is legal and has no side effect. req bits that are not granted are ignored that cycle.
- A word is never duplicated or dropped. Each gnt pulse corresponds to exactly one later out_valid&&out_ready transfer carrying that word.
- Reset mid-operation discards any held word. After reset release, arbitration restarts from requester 0.

Test Plan:
1. Reset: hold rst_n=0 with req=4'b1111 -> out_valid=0, out_data=0, out_sel=00, gnt=0000. Release, out_ready=1 -> first gnt=0001.
2. Single requester: req=0100, din2=8'hA5, out_ready=1 -> gnt=0100 in cycle n; cycle n+1 out_valid=1, out_data=A5, out_sel=10. Drop req -> out_valid=0 next cycle.
3. Full contention: req=1111, distinct din per slot, out_ready=1 for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,…; out_sel 00,01,10,11,00,… one per cycle, no gaps.
4. Backpressure: with out_valid=1 and out_sel=01, hold out_ready=0 for 3 cycles while req=1111 -> out_data/out_sel constant, gnt=0000. Raise out_ready -> gnt=0100 (pointer resumes at 2).
5. Skip idle: ptr=1, req=1001 -> gnt=1000 (requester 3), then ptr=0 -> next gnt=0001.
6. Async reset mid-stream: pull rst_n low between clock edges during a contention run -> out_valid drops immediately without a clock edge and gnt=0. After release, grants restart at requester 0.
